// File: rtl/hq2x_vga_out.sv
// VGA timing generator and output stage for the Hq2x scaler: reads the scaler line
// buffer, expands RGB555 to 6-bit VGA and locks frame timing to frame_available.
module hq2x_vga_out #(
    parameter int H_ACTIVE   = 512,
    parameter int H_FP       = 16,
    parameter int H_SYNC     = 48,
    parameter int H_BP       = 106,
    parameter int V_ACTIVE   = 480,
    parameter int V_FP       = 11,
    parameter int V_SYNC     = 2,
    parameter int V_BP       = 31,
    parameter bit HS_POL     = 1'b0,
    parameter bit VS_POL     = 1'b0,
    parameter int MISS_LIMIT = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        frame_available,
    input  logic [14:0] outpixel,
    output logic [9:0]  read_x,
    output logic [5:0]  vga_r,
    output logic [5:0]  vga_g,
    output logic [5:0]  vga_b,
    output logic        vga_hs,
    output logic        vga_vs,
    output logic        vga_de,
    output logic        locked,
    output logic        resync
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    // hcnt is at least 9 bits so read_x can always take hcnt[8:0]
    localparam int HW = ($clog2(H_TOTAL) < 9) ? 9 : $clog2(H_TOTAL);
    localparam int VW = ($clog2(V_TOTAL) < 1) ? 1 : $clog2(V_TOTAL);
    localparam int MW = ($clog2(MISS_LIMIT + 1) < 1) ? 1 : $clog2(MISS_LIMIT + 1);

    localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_ACT  = HW'(H_ACTIVE);
    localparam logic [HW-1:0] HS_BEG = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] HS_END = HW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_ACT  = VW'(V_ACTIVE);
    localparam logic [VW-1:0] VS_BEG = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] VS_END = VW'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [MW-1:0] MISS_MAX = MW'(MISS_LIMIT);

    typedef enum logic {SEARCH = 1'b0, RUN = 1'b1} state_t;

    state_t          state, state_nxt;
    logic [HW-1:0]   hcnt, hcnt_nxt;
    logic [VW-1:0]   vcnt, vcnt_nxt;
    logic [MW-1:0]   miss_cnt, miss_nxt;
    logic            fa_q, fa_edge, h_last, v_last, frame_wrap, force_sync, active_nxt;
    logic            de_p1, hs_p1, vs_p1;

    function automatic logic [5:0] expand5(input logic [4:0] c5);
        return {c5, c5[4]};
    endfunction

    assign fa_edge    = frame_available & ~fa_q;
    assign h_last     = (hcnt == H_LAST);
    assign v_last     = (vcnt == V_LAST);
    assign frame_wrap = h_last & v_last;
    assign locked     = (state == RUN);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= SEARCH;
            miss_cnt <= '0;
            fa_q     <= 1'b0;
        end else begin
            state    <= state_nxt;
            miss_cnt <= miss_nxt;
            fa_q     <= frame_available;
        end
    end

    // An edge landing on the frame wrap is already in phase; any other edge re-aligns.
    always_comb begin
        state_nxt  = state;
        miss_nxt   = miss_cnt;
        force_sync = 1'b0;
        case (state)
            SEARCH: begin
                if (fa_edge) begin
                    state_nxt  = RUN;
                    miss_nxt   = '0;
                    force_sync = 1'b1;
                end
            end
            RUN: begin
                if (fa_edge) begin
                    miss_nxt   = '0;
                    force_sync = ~frame_wrap;
                end else if (frame_wrap) begin
                    if (miss_cnt + MW'(1) >= MISS_MAX) begin
                        state_nxt = SEARCH;
                        miss_nxt  = '0;
                    end else begin
                        miss_nxt = miss_cnt + MW'(1);
                    end
                end
            end
            default: state_nxt = SEARCH;
        endcase
    end

    always_comb begin
        hcnt_nxt = h_last ? '0 : hcnt + HW'(1);
        vcnt_nxt = vcnt;
        if (h_last) vcnt_nxt = v_last ? '0 : vcnt + VW'(1);
        if (force_sync) begin
            hcnt_nxt = '0;
            vcnt_nxt = '0;
        end
        active_nxt = (hcnt_nxt < H_ACT) && (vcnt_nxt < V_ACT);
    end

    // p0: counters and read_x, both reflecting the same position
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hcnt   <= '0;
            vcnt   <= '0;
            read_x <= '0;
            resync <= 1'b0;
        end else begin
            hcnt   <= hcnt_nxt;
            vcnt   <= vcnt_nxt;
            read_x <= active_nxt ? {vcnt_nxt[0], hcnt_nxt[8:0]} : 10'd0;
            resync <= force_sync;
        end
    end

    // p1: sync/enable decoded from p0 counters, aligned with outpixel arriving
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            de_p1 <= 1'b0;
            hs_p1 <= ~HS_POL;
            vs_p1 <= ~VS_POL;
        end else begin
            de_p1 <= (hcnt < H_ACT) && (vcnt < V_ACT) && locked;
            hs_p1 <= (hcnt >= HS_BEG && hcnt < HS_END) ? HS_POL : ~HS_POL;
            vs_p1 <= (vcnt >= VS_BEG && vcnt < VS_END) ? VS_POL : ~VS_POL;
        end
    end

    // p2: output pins
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vga_de <= 1'b0;
            vga_hs <= ~HS_POL;
            vga_vs <= ~VS_POL;
            vga_r  <= '0;
            vga_g  <= '0;
            vga_b  <= '0;
        end else begin
            vga_de <= de_p1;
            vga_hs <= hs_p1;
            vga_vs <= vs_p1;
            vga_r  <= de_p1 ? expand5(outpixel[4:0])   : 6'd0;
            vga_g  <= de_p1 ? expand5(outpixel[9:5])   : 6'd0;
            vga_b  <= de_p1 ? expand5(outpixel[14:10]) : 6'd0;
        end
    end

endmodule

// File: tb/tb_hq2x_vga_out.sv
// Randomized scoreboard bench for hq2x_vga_out using a small frame geometry and a
// frame-position reference model.
module tb_hq2x_vga_out;

    localparam int HA = 16, HFP = 2, HSY = 3, HBP = 3;
    localparam int VA = 6,  VFP = 1, VSY = 2, VBP = 1;
    localparam int ML = 2;
    localparam int HT = HA + HFP + HSY + HBP;
    localparam int VT = VA + VFP + VSY + VBP;
    localparam int N  = HT * VT;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        frame_available = 1'b0;
    logic [14:0] outpixel = 15'd0;
    logic [9:0]  read_x;
    logic [5:0]  vga_r, vga_g, vga_b;
    logic        vga_hs, vga_vs, vga_de, locked, resync;

    hq2x_vga_out #(
        .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSY), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP),
        .HS_POL(1'b0), .VS_POL(1'b0), .MISS_LIMIT(ML)
    ) dut (
        .clk(clk), .reset_n(reset_n), .frame_available(frame_available),
        .outpixel(outpixel), .read_x(read_x),
        .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
        .vga_hs(vga_hs), .vga_vs(vga_vs), .vga_de(vga_de),
        .locked(locked), .resync(resync)
    );

    always #5 clk = ~clk;

    // scaler line buffer: registered read, data valid the clock after read_x
    logic [14:0] mem [1024];
    always @(posedge clk) outpixel <= mem[read_x];

    typedef struct packed {
        logic [9:0] rx;
        logic       lk, rs, hs, vs, de;
        logic [5:0] r, g, b;
    } exp_t;

    exp_t q[$];
    exp_t hist[$];
    exp_t mon_e, mon_a;
    int   n_cmp = 0, n_err = 0, cyc = 0;
    int   pos, misses;
    bit   m_locked, m_resync, fa_prev;

    function automatic logic [5:0] exp6(input int c5);
        return 6'(c5 * 2 + ((c5 >= 16) ? 1 : 0));
    endfunction

    function automatic exp_t reset_exp();
        exp_t e;
        e = '0;
        e.hs = 1'b1;
        e.vs = 1'b1;
        return e;
    endfunction

    function automatic exp_t dut_out();
        exp_t a;
        a.rx = read_x; a.lk = locked; a.rs = resync;
        a.hs = vga_hs; a.vs = vga_vs; a.de = vga_de;
        a.r = vga_r; a.g = vga_g; a.b = vga_b;
        return a;
    endfunction

    task automatic model_init();
        pos = 0; misses = 0; m_locked = 0; m_resync = 0; fa_prev = 0;
        hist.delete();
        hist.push_back(reset_exp());
        hist.push_back(reset_exp());
    endtask

    // expected pins for the current cycle; pixel stage delayed two cycles via hist
    task automatic push_exp();
        exp_t cur, e;
        int h, v, rx;
        bit act;
        logic [14:0] pix;
        h = pos % HT;
        v = pos / HT;
        act = (h < HA) && (v < VA);
        rx = act ? ((v % 2) * 512 + h) : 0;
        pix = mem[rx];
        cur = '0;
        cur.de = act && m_locked;
        cur.hs = !(h >= HA + HFP && h < HA + HFP + HSY);
        cur.vs = !(v >= VA + VFP && v < VA + VFP + VSY);
        cur.r = cur.de ? exp6(int'(pix[4:0]))   : 6'd0;
        cur.g = cur.de ? exp6(int'(pix[9:5]))   : 6'd0;
        cur.b = cur.de ? exp6(int'(pix[14:10])) : 6'd0;
        e = hist.pop_front();
        hist.push_back(cur);
        e.rx = 10'(rx);
        e.lk = m_locked;
        e.rs = m_resync;
        q.push_back(e);
    endtask

    task automatic model_update(input bit ev);
        bit wrap;
        wrap = (pos == N - 1);
        m_resync = 0;
        if (!m_locked) begin
            if (ev) begin
                pos = 0; m_locked = 1; m_resync = 1; misses = 0;
            end else begin
                pos = (pos + 1) % N;
            end
        end else if (ev) begin
            if (!wrap) m_resync = 1;
            pos = 0; misses = 0;
        end else if (wrap) begin
            pos = 0;
            misses++;
            if (misses >= ML) begin
                m_locked = 0; misses = 0;
            end
        end else begin
            pos++;
        end
    endtask

    task automatic step(input bit fa);
        bit ev;
        frame_available = fa;
        ev = fa && !fa_prev;
        fa_prev = fa;
        @(posedge clk);
        #1;
        model_update(ev);
        cyc++;
        push_exp();
    endtask

    // 0: no strobe, 1: in-phase strobe, 2: random strobe, 3: held high
    function automatic bit pick(input int mode);
        case (mode)
            1: return m_locked && (pos == N - 1);
            2: return $urandom_range(0, 99) < 2;
            3: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    task automatic run(input int n, input int mode);
        for (int i = 0; i < n; i++) step(pick(mode));
    endtask

    task automatic do_reset(input bit check);
        frame_available = 1'b0;
        reset_n = 1'b0;
        #1;
        if (check) begin
            mon_a = dut_out();
            n_cmp++;
            if (mon_a !== reset_exp()) begin
                n_err++;
                $display("FAIL async_reset got=%h need=%h", mon_a, reset_exp());
            end
        end
        q.delete();
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        cyc = 0;
        model_init();
        push_exp();
    endtask

    always @(negedge clk) begin
        if (q.size() != 0) begin
            mon_e = q.pop_front();
            mon_a = dut_out();
            n_cmp++;
            if (mon_a !== mon_e) begin
                n_err++;
                $display("FAIL pins cyc=%0d got rx=%0d lk=%0b rs=%0b hs=%0b vs=%0b de=%0b rgb=%h/%h/%h need rx=%0d lk=%0b rs=%0b hs=%0b vs=%0b de=%0b rgb=%h/%h/%h",
                         cyc, mon_a.rx, mon_a.lk, mon_a.rs, mon_a.hs, mon_a.vs, mon_a.de, mon_a.r, mon_a.g, mon_a.b,
                         mon_e.rx, mon_e.lk, mon_e.rs, mon_e.hs, mon_e.vs, mon_e.de, mon_e.r, mon_e.g, mon_e.b);
            end
        end
    end

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 15'($urandom);
        mem[3]       = 15'h7C1F;
        mem[512 + 5] = 15'h7C1F;
        mem[0]       = 15'h4210;

        do_reset(1'b0);
        run(2 * N + 7, 0);
        run($urandom_range(30, 200), 0);
        step(1'b1); step(1'b1); step(1'b1);
        run(11 * N, 1);

        // strobe arrives five clocks late
        while (pos != N - 1) step(1'b0);
        step(1'b0);
        while (pos != 4) step(1'b0);
        step(1'b1);
        run(3 * N, 1);

        run(4 * N, 2);
        run(2 * N, 1);
        run(3 * N + 10, 0);

        run(300, 3);
        run(N, 0);
        step(1'b1);
        run(N + 37, 1);
        do_reset(1'b1);
        run(N + 11, 0);
        run(3 * N, 2);
        step(1'b0);
        step(1'b0);
        @(negedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/hq2x_vga_out.md
# hq2x_vga_out

- Downstream consumer of the Hq2x scaler.
- Generates 31 kHz VGA timing and drives `read_x` into the scaler's output line buffer.
- Registers the returned RGB555 `outpixel`, expands it to 6-bit-per-channel VGA and delays sync/blank to match.
- Locks its vertical counter to the scaler's `frame_available` strobe. Runs on the scaler clock, one pixel per clock (682 clocks per output line = half an input line).

## Interface
- H_ACTIVE, 512, active pixels per line (≤512)
- H_FP, 16, horizontal front porch clocks
- H_SYNC, 48, hsync width clocks
- H_BP, 106, horizontal back porch clocks (H_TOTAL = 682)
- V_ACTIVE, 480, active lines
- V_FP, 11, vertical front porch lines
- V_SYNC, 2, vsync width lines
- V_BP, 31, vertical back porch lines (V_TOTAL = 524)
- HS_POL, 0, hsync active level
- VS_POL, 0, vsync active level
- MISS_LIMIT, 2, consecutive frames without strobe before lock is dropped
- clk  in  1  scaler/pixel clock
- reset_n  in  1  asynchronous, active-low reset
- frame_available  in  1  scaler frame strobe (rising edge used)
- outpixel  in  15  RGB555 from scaler, R=[4:0], G=[9:5], B=[14:10]; valid the clock after `read_x`
- read_x  out  10  {line parity, pixel index[8:0]} into scaler output buffer
- vga_r, vga_g, vga_b  out  6 each  pixel colour
- vga_hs, vga_vs  out  1 each  syncs
- vga_de  out  1  display enable
- locked  out  1  timing aligned to scaler frames
- resync  out  1  one-clock pulse when counters were forced to the lock point

## Operation
- Counters:
  - hcnt counts 0..H_TOTAL-1. On wrap, vcnt counts 0..V_TOTAL-1.
  - Both always advance, including while unlocked.
- Strobe edge: fa_q registers `frame_available`. edge = frame_available & !fa_q.
- Lock point: the clock after an edge has hcnt=0, vcnt=0.
- State SEARCH (reset state), locked=0:
  - On edge: force hcnt=0, vcnt=0 next clock, pulse resync, go to RUN, clear miss count.
- State RUN, locked=1:
  - Edge with hcnt=H_TOTAL-1 and vcnt=V_TOTAL-1: in phase. No counter action, miss count cleared.
  - Edge at any other position: force the lock point, pulse resync, stay in RUN, clear miss count.
  - Each frame wrap (vcnt V_TOTAL-1→0) without an edge in that frame increments the miss count.
  - When the miss count reaches MISS_LIMIT, go to SEARCH.
  - An edge on the same clock as the wrap counts as received.
- read_x:
  - Registered and updated with the counters.
  - Equals {vcnt[0], hcnt[8:0]} when hcnt<H_ACTIVE and vcnt<V_ACTIVE, else 0.
- Active region: hcnt<H_ACTIVE and vcnt<V_ACTIVE. de_raw = active & locked.
- Syncs:
  - hs_raw = HS_POL when H_ACTIVE+H_FP ≤ hcnt < H_ACTIVE+H_FP+H_SYNC, else !HS_POL.
  - vs_raw uses the same rule with vcnt and the V_ parameters.
  - Syncs are generated even while unlocked.
- Colour:
  - Expansion is c6 = {c5, c5[4]}. For example 5'h1F→6'h3F and 5'h10→6'h21.
  - vga_r/g/b = 0 whenever the delayed de is 0.

## Timing
- Pipeline: counters at clock n → read_x valid during n → outpixel valid during n+1 → vga_* registered at the end of n+1.
- Total latency is 2 clocks from counter value to pins. hs/vs/de pass through two matching register stages.
- Reset values:
  - counters 0, state SEARCH, miss count 0
  - read_x 0, vga_r/g/b 0, vga_de 0, locked 0, resync 0
  - vga_hs = !HS_POL, vga_vs = !VS_POL
- locked changes 1 clock after the deciding edge or wrap, and leads the de pipeline by 2 clocks.
- Forced resync:
  - Counters jump without finishing the line.
  - The one distorted line is accepted and no extra blanking is inserted.
- Async reset mid-line returns everything to reset values immediately. Lock reacquires on the next edge.
- A held-high `frame_available` produces only one edge.

## Test plan
- Free-run without strobe after reset: vga_hs low for 48 clocks every 682, vga_vs low for 2 lines every 524, vga_de=0, rgb=0, locked=0.
- Single strobe edge at arbitrary position:
  - resync pulses once and locked=1 next clock.
  - 2 clocks after lock, vga_de rises for 512 clocks.
  - read_x runs 0..511, then 512..1023 on the following line.
- Periodic strobe every 682×524 clocks, in phase: resync never pulses after the first lock and locked stays 1 for 10 frames.
- Strobe shifted by +5 clocks in RUN: one resync pulse, hcnt=0 on the next clock, locked stays 1.
- Strobe stopped: locked falls exactly at the 2nd frame wrap without an edge and rgb goes to 0.
- outpixel=15'h7C1F (B=31, G=0, R=31) during active video: vga_r=6'h3F, vga_g=0, vga_b=6'h3F two clocks after the matching read_x.
